// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared operation codes, read-select codes, default latencies
//               and FSM state type for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [3:0] C_OP_NONE  = 4'd0;
    localparam logic [3:0] C_OP_MULT  = 4'd1;
    localparam logic [3:0] C_OP_MULTU = 4'd2;
    localparam logic [3:0] C_OP_DIV   = 4'd3;
    localparam logic [3:0] C_OP_DIVU  = 4'd4;
    localparam logic [3:0] C_OP_MTHI  = 4'd5;
    localparam logic [3:0] C_OP_MTLO  = 4'd6;

    localparam logic [1:0] C_RD_ZERO  = 2'd0;
    localparam logic [1:0] C_RD_HI    = 2'd1;
    localparam logic [1:0] C_RD_LO    = 2'd2;

    localparam int C_DEF_MULT_TIME = 5;
    localparam int C_DEF_DIV_TIME  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic is_launch_op(input logic [3:0] op);
        return (op >= C_OP_MULT) && (op <= C_OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == C_OP_DIV) || (op == C_OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_core.sv
`default_nettype none
// ============================================================================
// Module      : mdu_core
// Description : Combinational 32x32 multiply/divide datapath producing the
//               64-bit {HI,LO} result and a divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_core
    import mdu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  op_i,
    output logic [63:0] result_o,
    output logic        div_zero_o
);

    logic signed [63:0] w_sa64;
    logic signed [63:0] w_sb64;
    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic               w_b_zero;
    logic               w_ovf;
    logic signed [31:0] w_sdivisor;
    logic        [31:0] w_udivisor;
    logic signed [31:0] w_squot;
    logic signed [31:0] w_srem;
    logic        [31:0] w_uquot;
    logic        [31:0] w_urem;

    assign w_sa64  = {{32{a_i[31]}}, a_i};
    assign w_sb64  = {{32{b_i[31]}}, b_i};
    assign w_sprod = w_sa64 * w_sb64;
    assign w_uprod = {32'd0, a_i} * {32'd0, b_i};

    // Substituting a divisor of 1 keeps the divider defined for /0 and turns
    // the 0x80000000 / -1 overflow into the required q=0x80000000, r=0.
    assign w_b_zero   = (b_i == 32'd0);
    assign w_ovf      = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    assign w_sdivisor = (w_b_zero || w_ovf) ? 32'sd1 : $signed(b_i);
    assign w_udivisor = w_b_zero ? 32'd1 : b_i;
    assign w_squot    = $signed(a_i) / w_sdivisor;
    assign w_srem     = $signed(a_i) % w_sdivisor;
    assign w_uquot    = a_i / w_udivisor;
    assign w_urem     = a_i % w_udivisor;

    always_comb begin
        result_o   = 64'd0;
        div_zero_o = w_b_zero && is_div_op(op_i);
        case (op_i)
            C_OP_MULT:  result_o = w_sprod;
            C_OP_MULTU: result_o = w_uprod;
            C_OP_DIV:   result_o = {w_srem, w_squot};
            C_OP_DIVU:  result_o = {w_urem, w_uquot};
            default:    result_o = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Execute-stage multi-cycle multiply/divide unit owning HI/LO,
//               with programmable latency and a Busy flag for hazard control.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DEF_MULT_TIME = C_DEF_MULT_TIME,
    parameter int DEF_DIV_TIME  = C_DEF_DIV_TIME
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOP,
    input  logic [3:0]  Time,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  ReadHILO,
    output logic        Busy,
    output logic [31:0] HILOOut
);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pend_hi_q;
    logic [31:0] pend_lo_q;
    logic        pend_dz_q;
    logic        busy_q;

    logic [63:0] w_result;
    logic        w_div_zero;
    logic [3:0]  cnt_d;

    mdu_core u_core (
        .a_i        (A),
        .b_i        (B),
        .op_i       (MDUOP),
        .result_o   (w_result),
        .div_zero_o (w_div_zero)
    );

    always_comb begin
        cnt_d = Time;
        if (Time == 4'd0) begin
            cnt_d = is_div_op(MDUOP) ? 4'(DEF_DIV_TIME) : 4'(DEF_MULT_TIME);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start && is_launch_op(MDUOP)) begin
                        pend_hi_q <= w_result[63:32];
                        pend_lo_q <= w_result[31:0];
                        pend_dz_q <= w_div_zero;
                        cnt_q     <= cnt_d;
                        busy_q    <= 1'b1;
                        state_q   <= ST_RUN;
                    end else if (MDUOP == C_OP_MTHI) begin
                        hi_q <= A;
                    end else if (MDUOP == C_OP_MTLO) begin
                        lo_q <= A;
                    end
                end
                ST_RUN: begin
                    // Launch/move requests here are stalled upstream and dropped.
                    if (cnt_q <= 4'd1) begin
                        if (!pend_dz_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy = busy_q;

    always_comb begin
        HILOOut = 32'd0;
        case (ReadHILO)
            C_RD_HI: HILOOut = hi_q;
            C_RD_LO: HILOOut = lo_q;
            default: HILOOut = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOP;
    logic [3:0]  Time;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  ReadHILO;
    logic        Busy;
    logic [31:0] HILOOut;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .MDUOP    (MDUOP),
        .Time     (Time),
        .A        (A),
        .B        (B),
        .ReadHILO (ReadHILO),
        .Busy     (Busy),
        .HILOOut  (HILOOut)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] v);
        ReadHILO = sel;
        #1;
        v = HILOOut;
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        logic [31:0] v;
        rd(C_RD_HI, v);
        check({tag, "_hi"}, v, hi);
        rd(C_RD_LO, v);
        check({tag, "_lo"}, v, lo);
    endtask

    // Launches one op and counts Busy cycles; inj drives an MTLO and a second
    // Start into the run to confirm both are ignored.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] t, input bit inj, output int n,
                          output logic [31:0] pre_hi, output logic [31:0] pre_lo);
        Start = 1'b1; MDUOP = op; A = a; B = b; Time = t;
        tick();
        Start = 1'b0; MDUOP = C_OP_NONE;
        n = 0;
        pre_hi = 32'hX; pre_lo = 32'hX;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            if (n == 1) begin
                rd(C_RD_HI, pre_hi);
                rd(C_RD_LO, pre_lo);
            end
            if (inj && n == 2) begin
                Start = 1'b0; MDUOP = C_OP_MTLO; A = 32'hDEAD_BEEF;
            end else if (inj && n == 3) begin
                Start = 1'b1; MDUOP = C_OP_DIV; A = 32'd1; B = 32'd1; Time = 4'd1;
            end else begin
                Start = 1'b0; MDUOP = C_OP_NONE;
            end
            tick();
        end
        Start = 1'b0; MDUOP = C_OP_NONE;
    endtask

    initial begin
        int          n;
        logic [31:0] ph, pl, v;

        reset = 1'b0; Start = 1'b0; MDUOP = C_OP_NONE; Time = 4'd0;
        A = 32'd0; B = 32'd0; ReadHILO = C_RD_ZERO;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_busy", 32'(Busy), 32'd0);
        chk_hilo("rst", 32'd0, 32'd0);

        run_op(C_OP_MULT, 32'hFFFF_FFFE, 32'd3, 4'd5, 1'b0, n, ph, pl);
        check("mult_busy_cycles", 32'(n), 32'd5);
        check("mult_pre_hi", ph, 32'd0);
        check("mult_pre_lo", pl, 32'd0);
        chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // Back-to-back launch in the cycle Busy drops, with ignored requests inside.
        run_op(C_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 4'd0, 1'b1, n, ph, pl);
        check("multu_busy_cycles", 32'(n), 32'd5);
        check("multu_pre_hi", ph, 32'hFFFF_FFFF);
        chk_hilo("multu", 32'd1, 32'hFFFF_FFFE);
        tick();
        check("multu_no_relaunch", 32'(Busy), 32'd0);
        chk_hilo("multu_after", 32'd1, 32'hFFFF_FFFE);

        run_op(C_OP_DIV, 32'hFFFF_FFF9, 32'd2, 4'd10, 1'b0, n, ph, pl);
        check("div_busy_cycles", 32'(n), 32'd10);
        chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op(C_OP_DIVU, 32'd7, 32'd0, 4'd0, 1'b0, n, ph, pl);
        check("divu0_busy_cycles", 32'(n), 32'd10);
        chk_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op(C_OP_DIVU, 32'd100, 32'd7, 4'd3, 1'b0, n, ph, pl);
        check("divu_busy_cycles", 32'(n), 32'd3);
        chk_hilo("divu", 32'd2, 32'd14);

        run_op(C_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd1, 1'b0, n, ph, pl);
        check("divovf_busy_cycles", 32'(n), 32'd1);
        chk_hilo("divovf", 32'd0, 32'h8000_0000);

        run_op(C_OP_DIV, 32'd7, 32'hFFFF_FFFE, 4'd2, 1'b0, n, ph, pl);
        chk_hilo("div_pos_neg", 32'd1, 32'hFFFF_FFFD);

        MDUOP = C_OP_MTHI; A = 32'h1234;
        tick();
        check("mthi_busy", 32'(Busy), 32'd0);
        rd(C_RD_HI, v);
        check("mthi_hi", v, 32'h1234);
        MDUOP = C_OP_MTLO; A = 32'h5678;
        tick();
        check("mtlo_busy", 32'(Busy), 32'd0);
        MDUOP = C_OP_NONE;
        chk_hilo("mthilo", 32'h1234, 32'h5678);

        rd(C_RD_ZERO, v);
        check("rd_sel0", v, 32'd0);
        rd(2'd3, v);
        check("rd_sel3", v, 32'd0);

        Start = 1'b1; MDUOP = 4'd7; A = 32'hAAAA_AAAA;
        tick();
        Start = 1'b0; MDUOP = C_OP_NONE;
        check("badop_busy", 32'(Busy), 32'd0);
        chk_hilo("badop", 32'h1234, 32'h5678);

        Start = 1'b1; MDUOP = C_OP_DIV; A = 32'd100; B = 32'd7; Time = 4'd10;
        tick();
        Start = 1'b0; MDUOP = C_OP_NONE;
        tick();
        tick();
        check("rstrun_busy_before", 32'(Busy), 32'd1);
        reset = 1'b0;
        #1;
        check("rstrun_busy", 32'(Busy), 32'd0);
        chk_hilo("rstrun", 32'd0, 32'd0);
        tick();
        reset = 1'b1;
        repeat (15) tick();
        check("rstrun_late_busy", 32'(Busy), 32'd0);
        chk_hilo("rstrun_late", 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
